// File: rtl/adc_pulse_generator_if.sv
// rtl/adc_pulse_generator_if.sv - sample-strobe, pulse-request and sample-output bundle for the pulse generator
interface adc_pulse_generator_if #(
    parameter int SIZE_ADC_DATA = 12
);
    logic                     ce;
    logic                     start;
    logic [SIZE_ADC_DATA-1:0] amplitude;
    logic [SIZE_ADC_DATA-1:0] output_data;
    logic                     busy;
    logic                     done;

    modport master (
        output ce, start, amplitude,
        input  output_data, busy, done
    );

    modport slave (
        input  ce, start, amplitude,
        output output_data, busy, done
    );
endinterface

// File: rtl/adc_pulse_generator.sv
// rtl/adc_pulse_generator.sv - step-plus-exponential-decay pulse synthesizer on a constant baseline
module adc_pulse_generator #(
    parameter int SIZE_ADC_DATA = 12,
    parameter int FRAC_BITS     = 8,
    parameter int TAU_SHIFT     = 5,
    parameter int BASELINE      = 100,
    parameter int MAX_LEN       = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    adc_pulse_generator_if.slave  bus
);
    localparam int ACC_W = SIZE_ADC_DATA + FRAC_BITS;
    localparam int CNT_W = $clog2(MAX_LEN + 1);
    localparam int OUT_W = SIZE_ADC_DATA + 1;

    typedef enum logic {IDLE, DECAY} state_t;

    state_t                   state, next_state;
    logic [ACC_W-1:0]         acc, acc_next, dec, acc_sub, amp_ext;
    logic [ACC_W:0]           acc_sum;
    logic [CNT_W-1:0]         cnt, cnt_next;
    logic                     pend;
    logic [SIZE_ADC_DATA-1:0] pend_amp;
    logic                     eff_pend;
    logic [SIZE_ADC_DATA-1:0] eff_amp;
    logic                     terminate;
    logic [OUT_W-1:0]         out_sum;
    logic [SIZE_ADC_DATA-1:0] out_next;
    logic [SIZE_ADC_DATA-1:0] out_q;
    logic                     busy_q, done_q;

    // A start arriving on the ce cycle itself is consumed immediately, bypassing pend.
    assign eff_pend = pend | bus.start;
    assign eff_amp  = bus.start ? bus.amplitude : pend_amp;
    assign amp_ext  = {eff_amp, {FRAC_BITS{1'b0}}};

    // Minimum step of 1 guarantees the decay reaches zero; subtraction floors at 0.
    assign dec     = ((acc >> TAU_SHIFT) == '0) ? ACC_W'(1) : (acc >> TAU_SHIFT);
    assign acc_sub = (acc > dec) ? (acc - dec) : '0;
    assign acc_sum = {1'b0, acc_sub} + {1'b0, amp_ext};

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            pend     <= 1'b0;
            pend_amp <= '0;
            out_q    <= SIZE_ADC_DATA'(BASELINE);
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= terminate;
            if (bus.ce) begin
                state  <= next_state;
                acc    <= acc_next;
                cnt    <= cnt_next;
                out_q  <= out_next;
                busy_q <= (next_state == DECAY);
                pend   <= 1'b0;
            end else if (bus.start) begin
                pend     <= 1'b1;
                pend_amp <= bus.amplitude;
            end
        end
    end

    always_comb begin
        next_state = state;
        acc_next   = acc;
        cnt_next   = cnt;
        terminate  = 1'b0;
        if (bus.ce) begin
            case (state)
                IDLE: begin
                    if (eff_pend) begin
                        acc_next   = amp_ext;
                        cnt_next   = '0;
                        next_state = DECAY;
                    end
                end
                DECAY: begin
                    if (eff_pend) begin
                        acc_next = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
                        cnt_next = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                        if ((acc_sub >> FRAC_BITS) == '0 || cnt_next == CNT_W'(MAX_LEN)) begin
                            acc_next   = '0;
                            next_state = IDLE;
                            terminate  = 1'b1;
                        end else begin
                            acc_next = acc_sub;
                        end
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        out_sum  = OUT_W'(BASELINE) + {1'b0, acc_next[ACC_W-1:FRAC_BITS]};
        out_next = out_sum[OUT_W-1] ? {SIZE_ADC_DATA{1'b1}} : out_sum[SIZE_ADC_DATA-1:0];
    end

    assign bus.output_data = out_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_adc_pulse_generator.sv
// tb/tb_adc_pulse_generator.sv - self-checking bench for adc_pulse_generator
module tb_adc_pulse_generator;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    adc_pulse_generator_if #(.SIZE_ADC_DATA(12)) bus();
    adc_pulse_generator dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {int out; bit busy; bit done;} exp_t;
    typedef struct {bit rst; bit ce; bit start; int amp; int out; bit busy; bit done;} vec_t;

    exp_t  sbq[$];
    vec_t  vecs[7];
    int    n_cmp = 0;
    int    n_bad = 0;

    longint m_acc;
    int     m_cnt, m_pamp, m_out;
    bit     m_pend, m_state, m_busy, m_done;

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic model_edge(input bit rst, input bit ce, input bit st, input int amp);
        longint dec, sub, sum;
        bit     ep;
        int     ea;
        if (rst) begin
            m_acc = 0; m_cnt = 0; m_pend = 0; m_pamp = 0; m_state = 0;
            m_out = 100; m_busy = 0; m_done = 0;
            return;
        end
        ep = m_pend || st;
        ea = st ? amp : m_pamp;
        m_done = 0;
        if (!ce) begin
            if (st) begin m_pend = 1; m_pamp = amp; end
            return;
        end
        if (!m_state) begin
            if (ep) begin m_acc = longint'(ea) * 256; m_cnt = 0; m_state = 1; end
        end else begin
            dec = m_acc / 32;
            if (dec == 0) dec = 1;
            sub = (m_acc > dec) ? m_acc - dec : 0;
            if (ep) begin
                sum = sub + longint'(ea) * 256;
                m_acc = (sum > 1048575) ? 1048575 : sum;
                m_cnt = 0;
            end else begin
                m_cnt++;
                if (sub / 256 == 0 || m_cnt == 1024) begin
                    m_acc = 0; m_state = 0; m_done = 1;
                end else begin
                    m_acc = sub;
                end
            end
        end
        m_pend = 0;
        m_out  = (100 + m_acc / 256 > 4095) ? 4095 : int'(100 + m_acc / 256);
        m_busy = m_state;
    endtask

    task automatic step(input bit rst, input bit ce, input bit st, input int amp);
        exp_t e;
        reset         = rst;
        bus.ce        = ce;
        bus.start     = st;
        bus.amplitude = amp[11:0];
        model_edge(rst, ce, st, amp);
        sbq.push_back('{m_out, m_busy, m_done});
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check("sb_out",  int'(bus.output_data), e.out);
        check("sb_busy", int'(bus.busy),        int'(e.busy));
        check("sb_done", int'(bus.done),        int'(e.done));
    endtask

    task automatic drain(input string name);
        bit seen = 0;
        int prev = int'(bus.output_data);
        for (int i = 0; i < 2000 && !seen; i++) begin
            step(0, 1, 0, 0);
            check({name, "_mono"}, int'(int'(bus.output_data) <= prev), 1);
            prev = int'(bus.output_data);
            if (bus.done) seen = 1;
        end
        check({name, "_done_seen"}, int'(seen), 1);
        check({name, "_end_out"},   int'(bus.output_data), 100);
        check({name, "_end_busy"},  int'(bus.busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev, diff;
        vecs[0] = '{1, 0, 0, 0,    100,  0, 0};
        vecs[1] = '{1, 0, 0, 0,    100,  0, 0};
        vecs[2] = '{1, 0, 0, 0,    100,  0, 0};
        vecs[3] = '{0, 1, 0, 0,    100,  0, 0};
        vecs[4] = '{0, 1, 1, 1000, 1100, 1, 0};
        vecs[5] = '{0, 1, 0, 0,    1068, 1, 0};
        vecs[6] = '{0, 1, 0, 0,    1038, 1, 0};

        @(posedge clk); #1;
        for (int i = 0; i < 7; i++) begin
            step(vecs[i].rst, vecs[i].ce, vecs[i].start, vecs[i].amp);
            check($sformatf("vec%0d_out", i),  int'(bus.output_data), vecs[i].out);
            check($sformatf("vec%0d_busy", i), int'(bus.busy), int'(vecs[i].busy));
            check($sformatf("vec%0d_done", i), int'(bus.done), int'(vecs[i].done));
        end
        drain("s2");
        step(0, 1, 0, 0);
        check("s2_done_single", int'(bus.done), 0);

        // pile-up on a decaying pulse
        step(0, 1, 1, 1000);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
        prev = int'(bus.output_data);
        step(0, 1, 1, 500);
        diff = int'(bus.output_data) - prev;
        check("s3_jump_range", int'(diff >= 470 && diff <= 500), 1);
        check("s3_busy", int'(bus.busy), 1);
        drain("s3");

        // saturation on stacked large pulses
        step(0, 1, 1, 4000);
        check("s4_first", int'(bus.output_data), 4095);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        step(0, 1, 1, 4000);
        check("s4_clamp", int'(bus.output_data), 4095);
        check("s4_acc_sat", int'(dut.acc), 1048575);
        drain("s4");

        // ce every 4th clk, start on a ce=0 clk
        step(0, 0, 0, 0);
        step(0, 0, 1, 1000);
        step(0, 0, 0, 0);
        check("s5_hold_pre", int'(bus.output_data), 100);
        step(0, 1, 0, 0);
        check("s5_first", int'(bus.output_data), 1100);
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 3; j++) begin
                step(0, 0, 0, 0);
                check("s5_hold", int'(bus.output_data), (k == 0) ? 1100 : 1068);
            end
            step(0, 1, 0, 0);
            check("s5_seq", int'(bus.output_data), (k == 0) ? 1068 : 1038);
        end
        drain("s5");

        // reset mid-pulse, then relaunch
        step(0, 1, 1, 1000);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        check("s6_rst_out",  int'(bus.output_data), 100);
        check("s6_rst_busy", int'(bus.busy), 0);
        check("s6_rst_done", int'(bus.done), 0);
        step(0, 1, 0, 0);
        check("s6_no_done", int'(bus.done), 0);
        step(0, 1, 1, 1000);
        check("s6_r1", int'(bus.output_data), 1100);
        step(0, 1, 0, 0);
        check("s6_r2", int'(bus.output_data), 1068);
        step(0, 1, 0, 0);
        check("s6_r3", int'(bus.output_data), 1038);
        drain("s6");

        // last start before a ce wins
        step(0, 0, 1, 700);
        step(0, 0, 1, 300);
        step(0, 1, 0, 0);
        check("lastwin_out", int'(bus.output_data), 400);
        drain("lastwin");

        // zero amplitude
        step(0, 1, 1, 0);
        check("zero_out",  int'(bus.output_data), 100);
        check("zero_busy", int'(bus.busy), 1);
        step(0, 1, 0, 0);
        check("zero_done",  int'(bus.done), 1);
        check("zero_idle",  int'(bus.busy), 0);
        check("zero_out2",  int'(bus.output_data), 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
